// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and default timing for the intersection
// phase controller.
//   phase_e         - controller state, encoding is also the o_phase output
//   DEF_*_CYC       - default phase lengths in enabled clock cycles
//   max3            - helper for sizing the phase timer
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2,
        PH_EMERG   = 2'd3
    } phase_e;

    localparam int DEF_N_DIR      = 4;
    localparam int DEF_GREEN_CYC  = 20;
    localparam int DEF_YELLOW_CYC = 4;
    localparam int DEF_ALLRED_CYC = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_next_dir.sv
// rr_next_dir: combinational round-robin search. Starting one past
// i_cur_dir and wrapping, returns the first approach with demand.
// The current approach itself is never selected.
//   i_cur_dir  - approach currently owning the green
//   i_demand   - per-approach demand, level
//   o_found    - some other approach has demand
//   o_next_dir - first demanding approach after i_cur_dir (i_cur_dir if none)
module rr_next_dir #(
    parameter  int N_DIR = 4,
    localparam int DIR_W = $clog2(N_DIR)
) (
    input  logic [DIR_W-1:0] i_cur_dir,
    input  logic [N_DIR-1:0] i_demand,
    output logic             o_found,
    output logic [DIR_W-1:0] o_next_dir
);

    always_comb begin
        int               idx;
        logic [DIR_W-1:0] w_idx;
        o_found    = 1'b0;
        o_next_dir = i_cur_dir;
        idx        = 0;
        w_idx      = '0;
        for (int i = 1; i < N_DIR; i++) begin
            idx   = (int'(i_cur_dir) + i) % N_DIR;
            w_idx = DIR_W'(idx);
            if (!o_found && i_demand[w_idx]) begin
                o_found    = 1'b1;
                o_next_dir = w_idx;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: timed GREEN -> YELLOW -> ALL_RED sequencer over
// N_DIR approaches with demand skipping and emergency preemption.
//   i_clk, i_rst_n   - clock, synchronous active-low reset
//   i_en             - advance enable; low freezes timer and state
//   i_demand         - per-approach demand, level
//   i_emerg_req      - emergency request, level (acted on at its rising edge)
//   i_emerg_dir      - approach to serve on preemption
//   o_allow_norm     - one-hot green (GREEN/EMERG only)
//   o_allow_yellow   - one-hot yellow (YELLOW only)
//   o_cur_dir        - approach owning current/last green
//   o_emerg_active   - high in EMERG
//   o_phase          - encoded state (phase_e)
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter  int N_DIR      = DEF_N_DIR,
    parameter  int GREEN_CYC  = DEF_GREEN_CYC,
    parameter  int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter  int ALLRED_CYC = DEF_ALLRED_CYC,
    localparam int DIR_W      = $clog2(N_DIR)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [N_DIR-1:0] i_demand,
    input  logic             i_emerg_req,
    input  logic [DIR_W-1:0] i_emerg_dir,
    output logic [N_DIR-1:0] o_allow_norm,
    output logic [N_DIR-1:0] o_allow_yellow,
    output logic [DIR_W-1:0] o_cur_dir,
    output logic             o_emerg_active,
    output logic [1:0]       o_phase
);

    localparam int TMR_W = $clog2(max3(GREEN_CYC, YELLOW_CYC, ALLRED_CYC) + 1);
    localparam logic [TMR_W-1:0] T_GREEN  = TMR_W'(GREEN_CYC - 1);
    localparam logic [TMR_W-1:0] T_YELLOW = TMR_W'(YELLOW_CYC - 1);
    localparam logic [TMR_W-1:0] T_ALLRED = TMR_W'(ALLRED_CYC - 1);

    phase_e           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [DIR_W-1:0] r_nxt_dir;
    logic [DIR_W-1:0] r_e_dir;
    logic             r_req_d;
    logic             r_pend;

    logic             w_found;
    logic [DIR_W-1:0] w_next_dir;
    logic             w_rise;
    logic [DIR_W-1:0] w_edir_in;
    logic             w_pend;
    logic [DIR_W-1:0] w_edir;

    function automatic logic [N_DIR-1:0] f_onehot(input logic [DIR_W-1:0] d);
        return N_DIR'(1) << d;
    endfunction

    rr_next_dir #(.N_DIR(N_DIR)) u_rr (
        .i_cur_dir  (o_cur_dir),
        .i_demand   (i_demand),
        .o_found    (w_found),
        .o_next_dir (w_next_dir)
    );

    // Rising edge is tracked even while i_en is low so a request arriving
    // during a freeze is not lost; it is consumed once the FSM advances.
    assign w_rise    = i_emerg_req && !r_req_d;
    assign w_edir_in = ({1'b0, i_emerg_dir} >= (DIR_W+1)'(N_DIR)) ? '0 : i_emerg_dir;
    assign w_pend    = r_pend || w_rise;
    assign w_edir    = w_rise ? w_edir_in : r_e_dir;

    assign o_phase   = r_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= PH_ALL_RED;
            r_timer        <= T_ALLRED;
            o_cur_dir      <= '0;
            r_nxt_dir      <= '0;
            r_e_dir        <= '0;
            r_req_d        <= 1'b0;
            r_pend         <= 1'b0;
            o_allow_norm   <= '0;
            o_allow_yellow <= '0;
            o_emerg_active <= 1'b0;
        end else begin
            r_req_d <= i_emerg_req;
            if (w_rise) begin
                r_pend  <= 1'b1;
                r_e_dir <= w_edir_in;
            end
            if (i_en) begin
                case (r_state)
                    PH_ALL_RED: begin
                        if (r_timer == '0) begin
                            if (w_pend) begin
                                r_state        <= PH_EMERG;
                                r_pend         <= 1'b0;
                                r_timer        <= '0;
                                o_cur_dir      <= w_edir;
                                o_allow_norm   <= f_onehot(w_edir);
                                o_emerg_active <= 1'b1;
                            end else begin
                                r_state      <= PH_GREEN;
                                r_timer      <= T_GREEN;
                                o_cur_dir    <= r_nxt_dir;
                                o_allow_norm <= f_onehot(r_nxt_dir);
                            end
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    PH_GREEN: begin
                        if (w_pend && (o_cur_dir == w_edir)) begin
                            // Already green on the emergency approach: no yellow.
                            r_state        <= PH_EMERG;
                            r_pend         <= 1'b0;
                            r_timer        <= '0;
                            o_emerg_active <= 1'b1;
                        end else if (w_pend || (r_timer == '0 && w_found)) begin
                            // Preemption truncates the green; pend stays set so
                            // ALL_RED exits into EMERG.
                            r_state        <= PH_YELLOW;
                            r_timer        <= T_YELLOW;
                            r_nxt_dir      <= w_pend ? w_edir : w_next_dir;
                            o_allow_norm   <= '0;
                            o_allow_yellow <= f_onehot(o_cur_dir);
                        end else if (r_timer == '0) begin
                            r_timer <= T_GREEN;   // hold-over, nobody else waiting
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    PH_YELLOW: begin
                        if (r_timer == '0) begin
                            r_state        <= PH_ALL_RED;
                            r_timer        <= T_ALLRED;
                            o_allow_yellow <= '0;
                            if (w_pend) r_nxt_dir <= w_edir;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    PH_EMERG: begin
                        if (!i_emerg_req) begin
                            r_state        <= PH_YELLOW;
                            r_timer        <= T_YELLOW;
                            r_nxt_dir      <= w_found ? w_next_dir : o_cur_dir;
                            o_allow_norm   <= '0;
                            o_allow_yellow <= f_onehot(o_cur_dir);
                            o_emerg_active <= 1'b0;
                        end
                    end
                    default: begin
                        r_state        <= PH_ALL_RED;
                        r_timer        <= T_ALLRED;
                        o_allow_norm   <= '0;
                        o_allow_yellow <= '0;
                        o_emerg_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] demand;
    logic       emerg_req;
    logic [1:0] emerg_dir;
    logic [3:0] allow_norm;
    logic [3:0] allow_yellow;
    logic [1:0] cur_dir;
    logic       emerg_active;
    logic [1:0] phase;

    traffic_phase_ctrl #(
        .N_DIR(4), .GREEN_CYC(5), .YELLOW_CYC(2), .ALLRED_CYC(1)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_en           (en),
        .i_demand       (demand),
        .i_emerg_req    (emerg_req),
        .i_emerg_dir    (emerg_dir),
        .o_allow_norm   (allow_norm),
        .o_allow_yellow (allow_yellow),
        .o_cur_dir      (cur_dir),
        .o_emerg_active (emerg_active),
        .o_phase        (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] ay;
        logic [1:0] cd;
        logic       ea;
        logic [1:0] ph;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle the DUT presents a state; compare it against the
    // expectation queued for that cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || allow_norm !== e.an || allow_yellow !== e.ay ||
                cur_dir !== e.cd || emerg_active !== e.ea || phase !== e.ph) begin
                errors++;
                $display("FAIL %s cyc=%0d got an=%b ay=%b cd=%0d ea=%b ph=%0d exp an=%b ay=%b cd=%0d ea=%b ph=%0d",
                         e.nm, cyc, allow_norm, allow_yellow, cur_dir, emerg_active, phase,
                         e.an, e.ay, e.cd, e.ea, e.ph);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] an, input logic [3:0] ay,
                        input logic [1:0] cd, input logic ea, input logic [1:0] ph,
                        input string nm);
        exp_t e;
        e.cyc = c; e.an = an; e.ay = ay; e.cd = cd; e.ea = ea; e.ph = ph; e.nm = nm;
        q.push_back(e);
    endtask

    // Expect the given outputs after each of the next n clock edges.
    task automatic run(input int n, input logic [3:0] an, input logic [3:0] ay,
                       input logic [1:0] cd, input logic ea, input logic [1:0] ph,
                       input string nm);
        repeat (n) begin
            push(cyc + 1, an, ay, cd, ea, ph, nm);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; demand = 4'b1111; emerg_req = 1'b0; emerg_dir = 2'd0;
        @(posedge clk); #1;
        push(cyc, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, "reset");
        rst_n = 1'b1;

        // Normal rotation with full demand
        run(5, 4'b0001, 4'b0000, 2'd0, 1'b0, 2'd1, "green0");
        run(2, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'd2, "yellow0");
        run(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, "allred0");
        // No other demand: green 1 holds over across three periods
        demand = 4'b0000;
        run(15, 4'b0010, 4'b0000, 2'd1, 1'b0, 2'd1, "holdover1");
        demand = 4'b1000;
        run(2, 4'b0000, 4'b0010, 2'd1, 1'b0, 2'd2, "yellow1");
        run(1, 4'b0000, 4'b0000, 2'd1, 1'b0, 2'd0, "allred1");
        demand = 4'b1111;
        run(5, 4'b1000, 4'b0000, 2'd3, 1'b0, 2'd1, "green3");
        run(2, 4'b0000, 4'b1000, 2'd3, 1'b0, 2'd2, "yellow3");
        run(1, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'd0, "allred3");
        run(2, 4'b0001, 4'b0000, 2'd0, 1'b0, 2'd1, "green0b");

        // Preempt to approach 2 while green on 0 at timer=3
        emerg_req = 1'b1; emerg_dir = 2'd2;
        run(2, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'd2, "preempt_yellow");
        run(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, "preempt_allred");
        run(2, 4'b0100, 4'b0000, 2'd2, 1'b1, 2'd3, "emerg2");
        emerg_dir = 2'd1;   // must be ignored while request held
        run(2, 4'b0100, 4'b0000, 2'd2, 1'b1, 2'd3, "emerg2_hold");
        emerg_req = 1'b0;
        run(2, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'd2, "emerg_exit_yellow");
        run(1, 4'b0000, 4'b0000, 2'd2, 1'b0, 2'd0, "emerg_exit_allred");
        demand = 4'b0100;
        run(5, 4'b1000, 4'b0000, 2'd3, 1'b0, 2'd1, "post_emerg_green3");
        run(2, 4'b0000, 4'b1000, 2'd3, 1'b0, 2'd2, "yellow3b");
        run(1, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'd0, "allred3b");
        run(1, 4'b0100, 4'b0000, 2'd2, 1'b0, 2'd1, "green2");

        // Preempt on the approach already green: straight to EMERG
        emerg_req = 1'b1; emerg_dir = 2'd2;
        run(3, 4'b0100, 4'b0000, 2'd2, 1'b1, 2'd3, "emerg_same");
        emerg_req = 1'b0;
        run(2, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'd2, "emerg_same_yellow");
        run(1, 4'b0000, 4'b0000, 2'd2, 1'b0, 2'd0, "emerg_same_allred");
        // No other demand: green returns to 2
        run(2, 4'b0100, 4'b0000, 2'd2, 1'b0, 2'd1, "green2_return");

        // Freeze mid-green, then resume the remaining three cycles
        en = 1'b0; demand = 4'b1111;
        run(10, 4'b0100, 4'b0000, 2'd2, 1'b0, 2'd1, "frozen");
        en = 1'b1;
        run(3, 4'b0100, 4'b0000, 2'd2, 1'b0, 2'd1, "resume_green2");
        run(1, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'd2, "yellow2");

        // Reset during yellow
        rst_n = 1'b0;
        run(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, "reset_mid_yellow");
        rst_n = 1'b1;
        run(5, 4'b0001, 4'b0000, 2'd0, 1'b0, 2'd1, "restart_green0");
        run(1, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'd2, "restart_yellow0");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised, timed successor to the one-hot direction-allow decoder. Sequences N_DIR approaches through GREEN -> YELLOW -> ALL_RED phases with per-phase cycle counts, skips approaches without demand, and supports an emergency-preemption override. Sits between the intersection sensor/request logic and the lamp drivers; the registered one-hot allow and yellow vectors replace the old combinational allow_*_norm outputs.

Parameters:
N_DIR, 4, number of approaches (2..16)
GREEN_CYC, 20, cycles of green per normal phase (>=2)
YELLOW_CYC, 4, cycles of yellow (>=1)
ALLRED_CYC, 2, cycles of all-red clearance (>=1)
DIR_W, $clog2(N_DIR), direction index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous and active-low
en  in  1  advance enable; low freezes timer and state
demand  in  N_DIR  per-approach vehicle/pedestrian demand, level
emerg_req  in  1  emergency preemption request, level
emerg_dir  in  DIR_W  approach to serve during preemption; sampled when emerg_req first seen
allow_norm  out  N_DIR  one-hot green; all zero outside GREEN/EMERG
allow_yellow  out  N_DIR  one-hot yellow; all zero outside YELLOW
cur_dir  out  DIR_W  approach owning current/last green
emerg_active  out  1  high while in EMERG state
phase  out  2  encoded state: 0 ALL_RED, 1 GREEN, 2 YELLOW, 3 EMERG

Behaviour:
- All outputs registered. Reset (rst_n=0 at clk edge): state ALL_RED, timer=ALLRED_CYC-1, cur_dir=0, nxt_dir=0, allow_norm=0, allow_yellow=0, emerg_active=0, phase=0. Reset mid-phase aborts immediately.
- Timer counts down by 1 per cycle when en=1; state changes when timer==0 and en=1; timer reloads to new phase length minus 1. Each phase lasts exactly its parameter count of enabled cycles.
- ALL_RED -> GREEN(nxt_dir); cur_dir<=nxt_dir. After reset, first green is approach 0 regardless of demand.
- GREEN, timer==0: search (cur_dir+1 .. cur_dir+N_DIR-1) mod N_DIR for first set demand bit. Found -> nxt_dir=found, go YELLOW. None -> stay GREEN on cur_dir, timer reloads (hold-over); own-direction demand irrelevant.
- YELLOW -> ALL_RED at expiry.
- Preemption: emerg_req rising (registered edge) latches e_dir=emerg_dir.
  - GREEN with cur_dir==e_dir: EMERG next cycle, no yellow.
  - GREEN on other dir: YELLOW immediately (green truncated), nxt_dir=e_dir.
  - YELLOW/ALL_RED: complete phase; nxt_dir overridden to e_dir; ALL_RED exit enters EMERG instead of GREEN.
- EMERG: allow_norm one-hot at e_dir, cur_dir=e_dir, timer idle. emerg_req low -> YELLOW on e_dir, then ALL_RED, then normal search from e_dir+1 (no demand found -> green returns to e_dir).
- emerg_dir changes while emerg_req held are ignored; re-request requires emerg_req low then high.
- en=0: all state, timer, outputs hold; emerg_req edge still latched and acted on once en=1.
- Invariant: allow_norm and allow_yellow never both non-zero; each at most one bit set. Any illegal encoded state -> ALL_RED.
- emerg_dir >= N_DIR: treated as 0.

Decomposition:
- Shared package traffic_pkg: phase_e enum (ALL_RED, GREEN, YELLOW, EMERG) with fixed 2-bit encoding; default phase-length constants.
- One sub-module: rr_next_dir, combinational round-robin search (cur_dir, demand) -> found, next_dir; reusable by other arbiters.

Test Plan:
- Reset, N_DIR=4, GREEN=5, YELLOW=2, ALLRED=1, demand=4'b1111: ALL_RED 1 cycle, allow_norm=0001 for 5 cycles, allow_yellow=0001 2 cycles, 1 all-red, then allow_norm=0010.
- demand=4'b0000 after first green: allow_norm stays 0001 indefinitely, no yellow ever; set demand=4'b1000 -> yellow 0001 at next expiry then green 1000.
- Green on dir 0 at timer=3, emerg_req=1 emerg_dir=2: yellow 0001 next cycle, all-red, then allow_norm=0100, emerg_active=1, phase=3 until emerg_req drops; then yellow 0100, all-red, green dir 3 (demand=1111).
- Green on dir 2, emerg_req with emerg_dir=2: phase=3 next cycle, allow_norm unchanged 0100, no yellow.
- en=0 for 10 cycles mid-green: outputs and timer frozen; resume completes remaining green cycles exactly.
- rst_n low for one cycle during YELLOW: next cycle all outputs zero, phase=0; sequence restarts with green on dir 0.
